// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline <-> hazard controller bundle: hazard/redirect/memory status in,
// stall/flush/forward controls, FSM state and statistics counters out.
interface hazard_stall_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             hazard_rs1;
  logic             hazard_rs2;
  logic             producer_is_load_rs1;
  logic             producer_is_load_rs2;
  logic             branch_taken_ex;
  logic             dmem_ready;
  logic             stall_if;
  logic             stall_id;
  logic             bubble_ex;
  logic             flush_id;
  logic             fwd_rs1_sel;
  logic             fwd_rs2_sel;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] loaduse_events;
  logic [CNT_W-1:0] flush_events;

  // Pipeline side: reports hazards, consumes the controls.
  modport master (
    output hazard_rs1, hazard_rs2, producer_is_load_rs1, producer_is_load_rs2,
           branch_taken_ex, dmem_ready,
    input  stall_if, stall_id, bubble_ex, flush_id, fwd_rs1_sel, fwd_rs2_sel,
           state_o, stall_cycles, loaduse_events, flush_events
  );

  // Controller side.
  modport slave (
    input  hazard_rs1, hazard_rs2, producer_is_load_rs1, producer_is_load_rs2,
           branch_taken_ex, dmem_ready,
    output stall_if, stall_id, bubble_ex, flush_id, fwd_rs1_sel, fwd_rs2_sel,
           state_o, stall_cycles, loaduse_events, flush_events
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Load-use stall / branch flush / forwarding controller for a 5-stage pipeline,
// with saturating statistics counters.
module hazard_stall_ctrl #(
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  hazard_stall_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [2:0] WCNT_INIT = 3'(LOAD_LAT - 1);

  state_t           state_q, state_d;
  logic [2:0]       wcnt_q, wcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, lu_cnt_q, flush_cnt_q;

  logic lu_hit, stall, flush, fwd1, fwd2, lu_start;

  assign lu_hit = (bus.producer_is_load_rs1 && bus.hazard_rs1) ||
                  (bus.producer_is_load_rs2 && bus.hazard_rs2);

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    stall    = 1'b0;
    flush    = 1'b0;
    fwd1     = 1'b0;
    fwd2     = 1'b0;
    lu_start = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.branch_taken_ex) begin
          flush = 1'b1;
        end else if (lu_hit) begin
          stall    = 1'b1;
          lu_start = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = LU_STALL;
            wcnt_d  = WCNT_INIT;
          end else begin
            state_d = MEM_WAIT;
          end
        end
        if (!stall) begin
          fwd1 = bus.hazard_rs1 && !bus.producer_is_load_rs1;
          fwd2 = bus.hazard_rs2 && !bus.producer_is_load_rs2;
        end
      end
      LU_STALL: begin
        stall  = 1'b1;
        wcnt_d = wcnt_q - 3'd1;
        if (wcnt_q == 3'd1) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        // Load data arrives through WB, so forwarding stays off on release.
        if (bus.dmem_ready) state_d = RUN;
        else                stall   = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      wcnt_q      <= '0;
      stall_cnt_q <= '0;
      lu_cnt_q    <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (stall && stall_cnt_q != '1)    stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (lu_start && lu_cnt_q != '1)    lu_cnt_q    <= lu_cnt_q + CNT_W'(1);
      if (flush && flush_cnt_q != '1)    flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  // Controls are gated by reset because the RUN-state outputs are input-driven.
  assign bus.stall_if       = stall & rst;
  assign bus.stall_id       = stall & rst;
  assign bus.bubble_ex      = stall & rst;
  assign bus.flush_id       = flush & rst;
  assign bus.fwd_rs1_sel    = fwd1 & rst;
  assign bus.fwd_rs2_sel    = fwd2 & rst;
  assign bus.state_o        = state_q;
  assign bus.stall_cycles   = stall_cnt_q;
  assign bus.loaduse_events = lu_cnt_q;
  assign bus.flush_events   = flush_cnt_q;

endmodule
